// File: rtl/uart_rx_ce.sv
// 8N1 / 8E1 UART receiver driven by a 16x oversample clock enable.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx_ce #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE_16X,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR
);

  localparam int unsigned SCNT_W = 4;
  localparam int unsigned BIDX_W = 4;
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(7);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(15);
  localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  logic rxd_m, rxd_s;

  state_t                 state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [BIDX_W-1:0]      bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d;
  logic                   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   pbit_q, pbit_d;
  logic                   perr_d;
`endif

  // Two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
    end
  end

  // Next-state and output logic; everything except VALID holds without CE
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bidx_d  = bidx_q;
    sr_d    = sr_q;
    data_d  = DATA;
    valid_d = 1'b0;
    ferr_d  = FRAME_ERR;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = PARITY_ERR;
`endif
    if (CE_16X) begin
      scnt_d = scnt_q + SCNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          scnt_d = '0;
          if (!rxd_s) state_d = ST_START;
        end
        ST_START: begin
          if (scnt_q == SCNT_MID) begin
            scnt_d = '0;
            if (!rxd_s) begin
              state_d = ST_DATA;
              bidx_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            sr_d   = {rxd_s, sr_q[DATA_BITS-1:1]};
            bidx_d = bidx_q + BIDX_W'(1);
            if (bidx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d  = '0;
            pbit_d  = rxd_s;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (scnt_q == SCNT_LAST) begin
            scnt_d  = '0;
            data_d  = sr_q;
            ferr_d  = ~rxd_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^sr_q) ^ pbit_q;
`endif
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          scnt_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      scnt_q    <= '0;
      bidx_q    <= '0;
      sr_q      <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bidx_q    <= bidx_d;
      sr_q      <= sr_d;
      DATA      <= data_d;
      VALID     <= valid_d;
      FRAME_ERR <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pbit_q     <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      pbit_q     <= pbit_d;
      PARITY_ERR <= perr_d;
    end
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ce.md
# uart_rx_ce

Serial receiver for the UART controller: consumes the one-cycle clock-enable strobe produced by the design's frequency dividers, running at 16× the baud rate. It deserialises 8N1 frames, or 8E1 frames when parity is compiled in, from the RXD pin. Each byte is presented on a parallel bus with a one-cycle valid pulse and per-frame error flags. It sits between the board RXD pin and the controller's command/loopback logic.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9; LSB first on the wire.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, asynchronous, active-high.
- CE_16X  in  1  oversample strobe, one CLK cycle wide, period = CLK/(16·baud); minimum period 2 CLK.
- RXD  in  1  asynchronous serial input, idle high.
- DATA  out  DATA_BITS  last received byte; held until next completed frame.
- VALID  out  1  one-CLK pulse: DATA and error flags updated.
- FRAME_ERR  out  1  stop bit sampled low in the frame reported by the last VALID.
- PARITY_ERR  out  1  parity mismatch in the frame reported by the last VALID; constant 0 without UART_RX_PARITY_EN.

## Operation
- RXD passes through a 2-flop synchroniser (rxd_s). Both flops reset to 1.
- 4-bit sample counter SCNT, bit index BIDX, and shift register SR advance only on CLK cycles with CE_16X=1. No state changes occur without CE_16X, except the VALID clear.
- FSM states:
  - IDLE: on CE with rxd_s=0 -> START, SCNT=0.
  - START: on CE SCNT++. At SCNT==7 (mid start bit): rxd_s=0 -> DATA, SCNT=0, BIDX=0; rxd_s=1 -> IDLE (false start, no output).
  - DATA: on CE SCNT++. At SCNT==15: SR={rxd_s, SR[DATA_BITS-1:1]}, SCNT=0, BIDX++. After bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
  - PARITY: at SCNT==15 capture rxd_s as PBIT -> STOP, SCNT=0.
  - STOP: at SCNT==15 sample stop bit. Load DATA=SR and FRAME_ERR=~rxd_s. Load PARITY_ERR=(^SR)^PBIT^0, i.e. even parity expected. Assert VALID. Go to IDLE.
- Sampling is mid-bit throughout: 8 CE after the detected falling edge, then every 16 CE.
- Returning to IDLE at mid stop bit allows back-to-back frames with zero idle time.
- A low stop bit still delivers DATA with FRAME_ERR=1. The receiver then re-arms in IDLE. A line held low re-enters START on the next CE.
- Errors are not sticky: each VALID overwrites both flags.

## Timing
- Reset values: DATA=0, VALID=0, FRAME_ERR=0, PARITY_ERR=0, FSM=IDLE, SCNT=0, BIDX=0, SR=0, synchroniser=1.
- VALID is registered. It is high exactly the one CLK cycle after the CE cycle that sampled the stop bit, and low on the next cycle regardless of CE.
- DATA, FRAME_ERR and PARITY_ERR change only in the same cycle VALID rises.
- RXD-to-detection latency: 2 CLK synchroniser plus wait for the next CE.
- RST mid-frame aborts immediately. No VALID is produced for the partial frame, and all outputs return to reset values.
- CE_16X asserted during reset is ignored.

## Configuration
- UART_RX_PARITY_EN defined: frame is start + DATA_BITS + even parity + stop. The PARITY state is present and PARITY_ERR is computed.
- Undefined: PARITY state and PBIT are omitted. DATA goes directly to STOP, and PARITY_ERR is tied to 0.

## Test plan
All scenarios use CLK 100 MHz, CE_16X every 4 CLK (1 bit = 64 CLK), DATA_BITS=8.
- Send 0xA5, 8N1 -> one VALID pulse, DATA=0xA5, FRAME_ERR=0, PARITY_ERR=0; no further VALID for 2000 CLK of idle.
- RXD low glitch of 20 CLK (5 CE) from idle -> FSM returns to IDLE at mid start bit; no VALID; DATA stays at its prior value.
- Send 0x3C with stop bit driven 0 -> VALID, DATA=0x3C, FRAME_ERR=1. Next frame 0x3D with a good stop bit -> FRAME_ERR=0.
- Back-to-back 0x01, 0xFF, 0x80 with no idle between frames -> three VALID pulses, DATA in that order, 640 CLK apart, no errors.
- Assert RST for 3 CLK in the middle of data bit 4 of 0x55 -> all outputs 0 and no VALID. A following 0xAA frame is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> PARITY_ERR=0. 0x07 with parity bit 0 -> VALID, DATA=0x07, PARITY_ERR=1.
